// File: rtl/cordic_pkg.sv
// Shared definitions for the folded CORDIC engine.
//   state_e    : engine sequencing states
//   mode_e     : i_func decoding (ROT = rotation, anything nonzero = vectoring)
//   calc_pi_2  : round(pi/2 * 2^frac)
//   atan_val   : round(atan(2^-i) * 2^frac), elementary angle of micro-rotation i
//   PI_2       : pi/2 at the default angle format (15 fractional bits)
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    ROT = 1'b0,
    VEC = 1'b1
  } mode_e;

  localparam int ANGLE_FRAC_DEF = 15;

  // Elaboration-time only: callers use these to build constants and tables.
  function automatic int calc_pi_2(input int frac);
    return $rtoi(1.5707963267948966 * (2.0 ** frac) + 0.5);
  endfunction

  function automatic int atan_val(input int i, input int frac);
    return $rtoi($atan(2.0 ** (-i)) * (2.0 ** frac) + 0.5);
  endfunction

  localparam int PI_2 = calc_pi_2(ANGLE_FRAC_DEF);

endpackage

// File: rtl/cordic_iter_stage.sv
// One CORDIC micro-rotation, purely combinational. The shift amount and the
// elementary angle arrive at runtime so a single instance serves every
// iteration of the folded engine.
//   x, y, z       : current vector and angle accumulator (signed)
//   shift         : iteration index i (arithmetic right shift amount)
//   atan_i        : elementary angle for this iteration
//   vec           : 1 = vectoring (drive y to 0), 0 = rotation (drive z to 0)
//   x_nxt..z_nxt  : rotated values
module cordic_iter_stage #(
  parameter int DW = 18,
  parameter int SW = 4
) (
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  input  logic signed [DW-1:0] z,
  input  logic        [SW-1:0] shift,
  input  logic signed [DW-1:0] atan_i,
  input  logic                 vec,
  output logic signed [DW-1:0] x_nxt,
  output logic signed [DW-1:0] y_nxt,
  output logic signed [DW-1:0] z_nxt
);

  logic signed [DW-1:0] xs, ys;
  logic                 neg;

  assign xs = x >>> shift;
  assign ys = y >>> shift;

  // Rotation follows the sign of the residual angle. In vectoring, x is kept
  // non-negative by the pre-rotation, so when x and y share a sign the vector
  // sits above the axis and must turn clockwise (the same step as a negative
  // residual angle) for y to converge on zero.
  assign neg = vec ? (x[DW-1] ~^ y[DW-1]) : z[DW-1];

  assign x_nxt = neg ? (x + ys) : (x - ys);
  assign y_nxt = neg ? (y - xs) : (y + xs);
  assign z_nxt = neg ? (z + atan_i) : (z - atan_i);

endmodule

// File: rtl/cordic_iter_engine.sv
// Folded CORDIC engine: one micro-rotation datapath reused NUM_ITER times per
// operand set, preceded by a quadrant pre-rotation covering the full +/-pi range.
// No gain compensation (outputs carry K ~= 1.64676).
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_valid/o_ready       : operand handshake (accepts only in IDLE)
//   i_func, i_x, i_y, i_z : mode (0 rotation, nonzero vectoring) and operands
//   o_valid/i_ready       : result handshake (held in DONE until taken)
//   o_x, o_y, o_z         : registered results
// Accept edge to o_valid = NUM_ITER+1 cycles; initiation interval NUM_ITER+3.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int NUM_ITER      = 12,
  parameter int FUNC_WIDTH    = 1,
  parameter int DATA_OP_WIDTH = 18,
  parameter int ANGLE_FRAC    = DATA_OP_WIDTH - 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [FUNC_WIDTH-1:0]    i_func,
  input  logic [DATA_OP_WIDTH-1:0] i_x,
  input  logic [DATA_OP_WIDTH-1:0] i_y,
  input  logic [DATA_OP_WIDTH-1:0] i_z,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_OP_WIDTH-1:0] o_x,
  output logic [DATA_OP_WIDTH-1:0] o_y,
  output logic [DATA_OP_WIDTH-1:0] o_z
);

  localparam int DW = DATA_OP_WIDTH;
  localparam int CW = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam logic signed [DW-1:0] PI2 = DW'(calc_pi_2(ANGLE_FRAC));

  state_e                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [FUNC_WIDTH-1:0]  func_q;
  logic signed [DW-1:0]   x_q, y_q, z_q;
  logic signed [DW-1:0]   px, py, pz;
  logic signed [DW-1:0]   x_nxt, y_nxt, z_nxt;
  logic signed [DW-1:0]   atan_tab [2**CW];
  logic                   is_vec, is_last;

  // Elementary angles, padded to a power of two so any counter value indexes.
  for (genvar g = 0; g < 2**CW; g++) begin : g_atan
    if (g < NUM_ITER) begin : g_val
      assign atan_tab[g] = DW'(atan_val(g, ANGLE_FRAC));
    end else begin : g_pad
      assign atan_tab[g] = '0;
    end
  end

  assign is_vec  = (func_q != FUNC_WIDTH'(ROT));
  assign is_last = (cnt == CW'(NUM_ITER - 1));

  cordic_iter_stage #(.DW(DW), .SW(CW)) u_stage (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .shift  (cnt),
    .atan_i (atan_tab[cnt]),
    .vec    (is_vec),
    .x_nxt  (x_nxt),
    .y_nxt  (y_nxt),
    .z_nxt  (z_nxt)
  );

  // Quadrant pre-rotation by +/-pi/2 so the iterations only ever see
  // angles inside the CORDIC convergence range.
  always_comb begin
    px = x_q;
    py = y_q;
    pz = z_q;
    if (!is_vec) begin
      if (z_q > PI2) begin
        px = -y_q; py = x_q;  pz = z_q - PI2;
      end else if (z_q < -PI2) begin
        px = y_q;  py = -x_q; pz = z_q + PI2;
      end
    end else if (x_q[DW-1]) begin
      if (!y_q[DW-1]) begin
        px = y_q;  py = -x_q; pz = z_q + PI2;
      end else begin
        px = -y_q; py = x_q;  pz = z_q - PI2;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = PRE;
      end
      PRE:  state_nxt = ITER;
      ITER: if (is_last) state_nxt = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt    <= '0;
      func_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      o_x    <= '0;
      o_y    <= '0;
      o_z    <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          func_q <= i_func;
          x_q    <= $signed(i_x);
          y_q    <= $signed(i_y);
          z_q    <= $signed(i_z);
        end
        PRE: begin
          x_q <= px;
          y_q <= py;
          z_q <= pz;
          cnt <= '0;
        end
        ITER: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          cnt <= is_last ? '0 : cnt + CW'(1);
          if (is_last) begin
            o_x <= x_nxt;
            o_y <= y_nxt;
            o_z <= z_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Randomised self-checking bench for cordic_iter_engine. Expected results come
// from ideal trigonometry scaled by the CORDIC gain; tolerances cover the
// finite-iteration angle residual and shift truncation.
module tb_cordic_iter_engine;

  localparam int  NI = 12;
  localparam int  DW = 18;
  localparam int  AF = DW - 3;
  localparam real K  = 1.646760258;
  localparam longint TOL_XY  = 64;
  localparam longint TOL_ZR  = 24;
  localparam longint TOL_ZV  = 40;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_valid, i_ready;
  logic [0:0]           i_func;
  logic [DW-1:0]        i_x, i_y, i_z;
  logic                 o_ready, o_valid;
  logic signed [DW-1:0] o_x, o_y, o_z;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_iter_engine #(
    .NUM_ITER(NI), .FUNC_WIDTH(1), .DATA_OP_WIDTH(DW), .ANGLE_FRAC(AF)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_func(i_func), .i_x(i_x), .i_y(i_y), .i_z(i_z),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_x(o_x), .o_y(o_y), .o_z(o_z)
  );

  task automatic chk(input string tag, input longint got, input longint exp,
                     input longint tol);
    longint d;
    checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d)", tag, got, exp, tol);
    end
  endtask

  // Ideal result: rotation turns (x,y) by z; vectoring reports magnitude and
  // accumulates the vector's angle onto z.
  task automatic model(input int func, input int x, input int y, input int z,
                       output longint ex, output longint ey, output longint ez);
    real s, a;
    s = 2.0 ** AF;
    if (func == 0) begin
      a  = real'(z) / s;
      ex = longint'(K * (x * $cos(a) - y * $sin(a)));
      ey = longint'(K * (y * $cos(a) + x * $sin(a)));
      ez = 0;
    end else begin
      ex = longint'(K * $sqrt(real'(x) * x + real'(y) * y));
      ey = 0;
      ez = longint'(real'(z) + $atan2(real'(y), real'(x)) * s);
    end
  endtask

  task automatic start_op(input int func, input int x, input int y, input int z);
    @(negedge clk);
    chk("ready_before_accept", o_ready, 1, 0);
    i_valid = 1'b1;
    i_func  = (func != 0);
    i_x     = DW'(x);
    i_y     = DW'(y);
    i_z     = DW'(z);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  // Waits for o_valid (bounded) and compares results; leaves DONE pending.
  task automatic finish_op(input int func, input int x, input int y, input int z,
                           input bit do_lat, output bit ok);
    longint ex, ey, ez;
    int n;
    model(func, x, y, z, ex, ey, ez);
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      #1 n++;
      if (o_valid) break;
    end
    ok = o_valid;
    if (!o_valid) chk("timeout_o_valid", 0, 1, 0);
    else begin
      if (do_lat) chk("latency", n, NI + 1, 0);
      chk(func ? "vec_x" : "rot_x", o_x, ex, TOL_XY);
      chk(func ? "vec_y" : "rot_y", o_y, ey, TOL_XY);
      chk(func ? "vec_z" : "rot_z", o_z, ez, func ? TOL_ZV : TOL_ZR);
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    chk("valid_drop", o_valid, 0, 0);
    chk("ready_back", o_ready, 1, 0);
  endtask

  task automatic run_op(input int func, input int x, input int y, input int z,
                        input bit do_lat);
    bit ok;
    start_op(func, x, y, z);
    finish_op(func, x, y, z, do_lat, ok);
    release_op();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    int hx, hy, hz;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_func = '0; i_x = '0; i_y = '0; i_z = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0, 0);
    chk("rst_ready", o_ready, 1, 0);
    chk("rst_x", o_x, 0, 0);
    chk("rst_y", o_y, 0, 0);
    chk("rst_z", o_z, 0, 0);

    // Directed points, including both pre-rotation boundaries.
    run_op(0, 19898, 0, 0, 1);
    run_op(0, 19898, 0, 51472, 1);
    run_op(1, 16384, 16384, 0, 1);
    run_op(1, -16384, 0, 0, 1);
    run_op(0, 20000, 5000, 102944, 1);
    run_op(0, 20000, 5000, -102944, 1);

    // Backpressure: result held for 5 cycles, new operands ignored.
    start_op(0, 12000, -7000, 30000);
    finish_op(0, 12000, -7000, 30000, 0, ok);
    hx = o_x; hy = o_y; hz = o_z;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      i_valid = 1'b1; i_func = 1'b1; i_x = DW'(1000); i_y = DW'(2000); i_z = '0;
      @(posedge clk);
      #1;
      chk("bp_valid", o_valid, 1, 0);
      chk("bp_ready", o_ready, 0, 0);
      chk("bp_hold_x", o_x, hx, 0);
      chk("bp_hold_y", o_y, hy, 0);
      chk("bp_hold_z", o_z, hz, 0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    release_op();
    repeat (3) @(posedge clk);
    #1 chk("bp_no_accept", o_ready, 1, 0);

    // Reset while the counter sits at 5: outputs cleared at once.
    start_op(0, 25000, 1000, 40000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", o_valid, 0, 0);
    chk("midrst_x", o_x, 0, 0);
    chk("midrst_y", o_y, 0, 0);
    chk("midrst_z", o_z, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_ready", o_ready, 1, 0);
    run_op(0, 25000, 1000, 40000, 1);

    // Random operand sets.
    for (int t = 0; t < 30; t++) begin
      int f, x, y, z;
      f = int'($urandom_range(0, 1));
      if (f == 0) begin
        x = int'($urandom_range(0, 80000)) - 40000;
        y = int'($urandom_range(0, 80000)) - 40000;
        z = int'($urandom_range(0, 205888)) - 102944;
      end else begin
        do begin
          x = int'($urandom_range(0, 80000)) - 40000;
          y = int'($urandom_range(0, 80000)) - 40000;
        end while (real'(x) * x + real'(y) * y < 16384.0 * 16384.0);
        z = int'($urandom_range(0, 32768)) - 16384;
      end
      run_op(f, x, y, z, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
